// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM test-master FSM state type.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DRAIN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ahbl_sram_test_master_if.sv
// AHB-Lite bus bundle shared by an initiator and a target.
interface ahbl_sram_test_master_if #(
  parameter int unsigned AHB_AWIDTH = 32,
  parameter int unsigned AHB_DWIDTH = 32
) ();

  logic [AHB_AWIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [AHB_DWIDTH-1:0] HWDATA;
  logic [AHB_DWIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahbl_sram_test_master.sv
// AHB-Lite initiator that fills or verifies an SRAM region with an
// incrementing-word pattern using pipelined INCR word bursts.
module ahbl_sram_test_master
  import ahbl_pkg::*;
#(
  parameter int unsigned AHB_AWIDTH = 32,
  parameter int unsigned AHB_DWIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic                  cmd_write,
  input  logic [AHB_AWIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [AHB_DWIDTH-1:0] cmd_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  mism_cnt,
  output logic [AHB_AWIDTH-1:0] mism_addr,
  ahbl_sram_test_master_if.master bus
);

  state_e                state_q;
  logic [AHB_AWIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic                  hwrite_q;
  logic [AHB_DWIDTH-1:0] hwdata_q;
  logic [AHB_DWIDTH-1:0] pat_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  dvalid_q;
  logic [AHB_AWIDTH-1:0] daddr_q;
  logic [AHB_DWIDTH-1:0] dexp_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [LEN_WIDTH-1:0]  mcnt_q;
  logic [AHB_AWIDTH-1:0] maddr_q;

  logic [AHB_AWIDTH-1:0] addr_inc_d;
  logic                  err_hit_d;
  logic                  rd_miss_d;

  assign addr_inc_d = haddr_q + AHB_AWIDTH'(4);
  // first cycle of a two-cycle ERROR response on the outstanding data phase
  assign err_hit_d  = dvalid_q && !bus.HREADY && (bus.HRESP == HRESP_ERROR);
  assign rd_miss_d  = dvalid_q && bus.HREADY && (bus.HRESP == HRESP_OKAY) &&
                      !hwrite_q && (bus.HRDATA != dexp_q);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      pat_q    <= '0;
      remain_q <= '0;
      dvalid_q <= 1'b0;
      daddr_q  <= '0;
      dexp_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
      maddr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (rd_miss_d) begin
        if (mcnt_q != '1) mcnt_q <= mcnt_q + LEN_WIDTH'(1);
        if (mcnt_q == '0) maddr_q <= daddr_q;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q   <= 1'b0;
            mcnt_q  <= '0;
            maddr_q <= '0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q   <= 1'b1;
              haddr_q  <= cmd_addr & ~AHB_AWIDTH'(3);
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= cmd_write;
              pat_q    <= cmd_seed;
              remain_q <= cmd_len - LEN_WIDTH'(1);
              dvalid_q <= 1'b0;
              state_q  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (err_hit_d) begin
            err_q    <= 1'b1;
            maddr_q  <= daddr_q;
            htrans_q <= HTRANS_IDLE;
            dvalid_q <= 1'b0;
            state_q  <= ST_ERR;
          end else if (bus.HREADY) begin
            dvalid_q <= 1'b1;
            daddr_q  <= haddr_q;
            dexp_q   <= pat_q;
            hwdata_q <= pat_q;
            if (remain_q == '0) begin
              htrans_q <= HTRANS_IDLE;
              state_q  <= ST_DRAIN;
            end else begin
              haddr_q  <= addr_inc_d;
              htrans_q <= (addr_inc_d[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
              pat_q    <= pat_q + AHB_DWIDTH'(1);
              remain_q <= remain_q - LEN_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (err_hit_d) begin
            err_q    <= 1'b1;
            maddr_q  <= daddr_q;
            dvalid_q <= 1'b0;
            state_q  <= ST_ERR;
          end else if (bus.HREADY) begin
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (bus.HREADY) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.HADDR  = haddr_q;
  assign bus.HTRANS = htrans_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HBURST = HBURST_INCR;
  assign bus.HWDATA = hwdata_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mism_cnt  = mcnt_q;
  assign mism_addr = maddr_q;

endmodule

// File: tb/tb_ahbl_sram_test_master.sv
// Scoreboard bench: SRAM slave model with wait states and ERROR injection,
// expectations from a word-level reference of the fill/verify rules.
module tb_ahbl_sram_test_master;

  logic        HCLK;
  logic        HRESET;
  logic        start;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] cmd_seed;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mism_cnt;
  logic [31:0] mism_addr;

  ahbl_sram_test_master_if bus ();

  ahbl_sram_test_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .busy(busy), .done(done), .err(err), .mism_cnt(mism_cnt),
    .mism_addr(mism_addr), .bus(bus)
  );

  typedef struct packed {
    logic        err;
    logic [15:0] cnt;
    logic [31:0] maddr;
    int          lat;
  } res_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  bit mon_quiet = 0;

  logic [34:0] aq[$];
  logic [31:0] wq[$];
  res_t        rq[$];

  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  int cfg_ws = 0;
  int cfg_errb = -1;
  int s_beat = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // SRAM slave: decides next-cycle response at negedge, drives it after posedge
  initial begin : slave
    bit          s_dp = 0, s_write = 0, s_err = 0;
    logic [31:0] s_addr = 0;
    int          s_wait = 0, s_stage = 0;
    logic        n_ready;
    logic [1:0]  n_resp;
    logic [31:0] n_rdata;
    bus.HREADY = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      n_ready = 1'b1; n_resp = 2'b00; n_rdata = '0;
      if (HRESET) begin
        s_dp = 0;
      end else begin
        if (s_dp && bus.HREADY) begin
          if (s_write && bus.HRESP == 2'b00) smem[s_addr] = bus.HWDATA;
          s_dp = 0;
        end
        if (bus.HREADY && bus.HTRANS[1]) begin
          s_dp = 1; s_addr = bus.HADDR; s_write = bus.HWRITE;
          s_err = (s_beat == cfg_errb); s_beat++; s_wait = cfg_ws; s_stage = 0;
        end
        if (s_dp) begin
          if (s_err) begin
            n_resp = 2'b01; n_ready = (s_stage != 0); s_stage++;
          end else if (s_wait > 0) begin
            n_ready = 1'b0; s_wait--;
          end else if (!s_write) begin
            n_rdata = smem.exists(s_addr) ? smem[s_addr] : 32'h0;
          end
        end
      end
      @(posedge HCLK); #1;
      bus.HREADY = n_ready; bus.HRESP = n_resp; bus.HRDATA = n_rdata;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus beat or done
  initial begin : monitor
    bit          mdp = 0, mdp_write = 0;
    logic [31:0] pv_addr = 0, pv_wdata = 0;
    logic [1:0]  pv_trans = 0, pv_resp = 0;
    logic        pv_ready = 1, pv_write = 0;
    res_t        r;
    forever begin
      @(negedge HCLK);
      cyc++;
      if (HRESET || mon_quiet) begin
        mdp = 0; pv_ready = 1; pv_trans = 0; pv_resp = 0;
      end else begin
        if (!pv_ready && pv_trans != 2'b00 && pv_resp == 2'b00) begin
          chk("hold_aphase", {bus.HADDR, bus.HTRANS, bus.HWRITE}, {pv_addr, pv_trans, pv_write});
          chk("hold_wdata", bus.HWDATA, pv_wdata);
        end
        if (pv_resp == 2'b01 && !pv_ready) chk("err_cycle2_idle", bus.HTRANS, 2'b00);
        if (mdp && bus.HREADY) begin
          if (bus.HRESP == 2'b00 && mdp_write) begin
            if (wq.size() == 0) fail_msg("unexpected_wdata");
            else chk("hwdata", bus.HWDATA, wq.pop_front());
          end
          mdp = 0;
        end
        if (bus.HREADY && bus.HTRANS[1]) begin
          if (aq.size() == 0) fail_msg("unexpected_beat");
          else chk("aphase", {bus.HADDR, bus.HTRANS, bus.HWRITE}, aq.pop_front());
          mdp = 1; mdp_write = bus.HWRITE;
        end
        if (done) begin
          done_cnt++;
          if (rq.size() == 0) fail_msg("unexpected_done");
          else begin
            r = rq.pop_front();
            chk("done_err", err, r.err);
            chk("done_mism_cnt", mism_cnt, r.cnt);
            chk("done_mism_addr", mism_addr, r.maddr);
            chk("done_busy", busy, 1'b0);
            if (r.lat >= 0) chk("latency", cyc - start_cyc, r.lat);
          end
        end
        pv_addr = bus.HADDR; pv_trans = bus.HTRANS; pv_write = bus.HWRITE;
        pv_wdata = bus.HWDATA; pv_ready = bus.HREADY; pv_resp = bus.HRESP;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus"}, {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST}, {32'h0, 2'b00, 1'b0, 3'b010, 3'b001});
    chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
    chk({tag, "_status"}, {busy, done, err, mism_cnt}, 19'h0);
    chk({tag, "_mism_addr"}, mism_addr, 32'h0);
  endtask

  // Reference: word-level expectations for one command, then drive it
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len,
                         input logic [31:0] seed, input int ws, input int errb,
                         input bit chk_lat);
    logic [31:0] a, pat, cur;
    res_t r;
    int d0, t;
    a = addr & 32'hFFFF_FFFC;
    r.err = 0; r.cnt = 0; r.maddr = 0;
    r.lat = chk_lat ? ((len == 0) ? 1 : len + 2) : -1;
    for (int i = 0; i < len; i++) begin
      pat = seed + 32'(i);
      aq.push_back({a, ((i == 0) || (a[9:0] == 10'd0)) ? 2'b10 : 2'b11, wr});
      if (i == errb) begin
        r.err = 1; r.maddr = a;
        break;
      end
      if (wr) begin
        wq.push_back(pat);
        rmem[a] = pat;
      end else begin
        cur = rmem.exists(a) ? rmem[a] : 32'h0;
        if (cur != pat) begin
          if (r.cnt == 0) r.maddr = a;
          if (r.cnt != 16'hFFFF) r.cnt++;
        end
      end
      a = a + 32'd4;
    end
    rq.push_back(r);
    cfg_ws = ws; cfg_errb = errb; s_beat = 0;
    d0 = done_cnt;
    @(posedge HCLK); #1;
    start = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len); cmd_seed = seed;
    start_cyc = cyc + 1;
    @(posedge HCLK); #1;
    start = 0;
    chk("busy_after_start", busy, (len != 0));
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge HCLK); t++;
    end
    if (done_cnt == d0) fail_msg("done_timeout");
    repeat (2) @(posedge HCLK);
    chk("beats_consumed", aq.size(), 0);
    chk("wdata_consumed", wq.size(), 0);
    chk("done_count", done_cnt - d0, 1);
    aq.delete(); wq.delete(); rq.delete();
  endtask

  initial begin : stim
    int len, errb;
    logic [31:0] addr;
    start = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_seed = 0;
    HRESET = 1;
    repeat (3) @(posedge HCLK);
    #1;
    chk_reset_vals("reset");
    HRESET = 0;
    repeat (2) @(posedge HCLK);

    run_cmd(1, 32'h100, 4, 32'hA0, 0, -1, 1);
    run_cmd(0, 32'h100, 4, 32'hA0, 2, -1, 0);
    smem[32'h108] = 32'hDEAD; rmem[32'h108] = 32'hDEAD;
    run_cmd(0, 32'h100, 4, 32'hA0, 0, -1, 1);
    chk("preload_mism_cnt", mism_cnt, 16'd1);
    chk("preload_mism_addr", mism_addr, 32'h108);
    run_cmd(1, 32'h3FC, 3, 32'h5000, 0, -1, 1);
    run_cmd(1, 32'h200, 8, 32'h77, 0, 1, 0);
    chk("error_flag_held", err, 1'b1);
    run_cmd(0, 32'h240, 0, 32'h0, 0, -1, 1);

    // reset in the middle of a long read
    mon_quiet = 1; cfg_ws = 1; cfg_errb = -1; s_beat = 0;
    @(posedge HCLK); #1;
    start = 1; cmd_write = 0; cmd_addr = 32'h100; cmd_len = 16'd16; cmd_seed = 32'h1;
    @(posedge HCLK); #1;
    start = 0;
    repeat (5) @(posedge HCLK);
    #1;
    chk("midburst_busy", busy, 1'b1);
    HRESET = 1;
    @(posedge HCLK); #1;
    chk_reset_vals("midburst_reset");
    HRESET = 0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("post_reset_idle", {busy, bus.HTRANS}, 3'b000);
    mon_quiet = 0;

    for (int k = 0; k < 24; k++) begin
      len  = $urandom_range(0, 10);
      addr = 32'h300 + 32'(4 * $urandom_range(0, 200)) + 32'($urandom_range(0, 3));
      errb = ($urandom_range(0, 4) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
      run_cmd(1'($urandom_range(0, 1)), addr, len, $urandom, $urandom_range(0, 2), errb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahbl_sram_test_master.md
Name: ahbl_sram_test_master

Overview:
AHB-Lite initiator that fills or verifies a region of the AHB-Lite LSRAM slave with an incrementing-word pattern. It issues pipelined INCR word bursts and honours slave wait states and ERROR responses. It reports the number of read mismatches and the first failing address. It sits on the AHB-Lite bus alongside the CPU master, as a bring-up and BIST engine for on-chip SRAM.

Parameters:
AHB_AWIDTH, 32, address width
AHB_DWIDTH, 32, data width (word transfers only)
LEN_WIDTH, 16, width of the transfer-count field (beats)

Ports:
HCLK  in  1  bus clock
HRESET  in  1  synchronous active-high reset
start  in  1  one-cycle command strobe; ignored while busy=1
cmd_write  in  1  1 = fill pattern, 0 = read and compare
cmd_addr  in  AHB_AWIDTH  start byte address; bits [1:0] forced to 0
cmd_len  in  LEN_WIDTH  beat count; 0 = no bus activity
cmd_seed  in  AHB_DWIDTH  pattern base value
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
err  out  1  HRESP ERROR seen; valid with done, held until next start
mism_cnt  out  LEN_WIDTH  read mismatches; saturates at all-ones
mism_addr  out  AHB_AWIDTH  address of the first mismatch or the ERROR beat
HADDR  out  AHB_AWIDTH  AHB address
HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11
HWRITE  out  1  transfer direction
HSIZE  out  3  constant 3'b010
HBURST  out  3  constant 3'b001 (INCR)
HWDATA  out  AHB_DWIDTH  write data
HRDATA  in  AHB_DWIDTH  read data
HREADY  in  1  bus ready (transfer completion)
HRESP  in  2  00 = OKAY, 01 = ERROR

Behaviour:
- Reset values: all outputs 0, except HSIZE=010 and HBURST=001. FSM returns to IDLE on the next clock edge, even mid-burst.
- All bus outputs are registered.
- Pattern: beat i carries cmd_seed + i, modulo 2^AHB_DWIDTH.
- FSM states: IDLE, ADDR, DRAIN, ERR.
  - IDLE: on start with cmd_len!=0, latch the command, clear err, mism_cnt and mism_addr, and set busy. The next cycle drives beat 0 as NONSEQ and the FSM enters ADDR.
  - IDLE: on start with cmd_len=0, done pulses next cycle, busy stays 0, and HTRANS stays IDLE.
  - ADDR: the address phase of beat i overlaps the data phase of beat i-1.
    - When HREADY=1 the address advances by 4 (wraps at 2^AHB_AWIDTH).
    - HTRANS is NONSEQ when the new address has bits [9:0]=0 (1 KB boundary); otherwise SEQ.
    - While HREADY=0, HADDR, HTRANS, HWRITE and HWDATA are held.
    - When the last beat's address phase is accepted, HTRANS becomes IDLE and the FSM moves to DRAIN.
  - DRAIN: wait for the final data phase (HREADY=1), then pulse done, drop busy, and return to IDLE.
- HWDATA for beat i is presented in the cycle after beat i's address is accepted.
- Read compare: sampled when HREADY=1 and HRESP=OKAY during a read data phase.
  - On HRDATA != expected, increment mism_cnt (saturating).
  - On the first mismatch only, capture its address.
- ERROR (HRESP=01 with HREADY=0, first cycle of the two-cycle response):
  - Set err and capture the failing beat address.
  - Force HTRANS=IDLE on the next cycle, which cancels the pending beat; the slave samples IDLE on the second ERROR cycle.
  - Enter ERR. On HREADY=1, pulse done, drop busy, return to IDLE. No further beats are issued.
- Simultaneous start with done: start is ignored; busy is 0 only in IDLE.
- Zero-wait-state slave: throughput is one beat per cycle. Latency from start to done for N beats is N+2 cycles.

Decomposition:
- Shared package ahbl_pkg holds:
  - HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ
  - HSIZE_WORD, HBURST_INCR
  - HRESP_OKAY, HRESP_ERROR
  - the FSM state enum
- No sub-module is required. The pattern/compare datapath stays inline.

Test Plan:
- Write 4 beats, addr=0x100, seed=0xA0, zero-wait slave -> HTRANS NONSEQ,SEQ,SEQ,SEQ; HWDATA 0xA0..0xA3 one cycle after each address; done at cycle 6 after start; err=0.
- Read-back of the same region with the SRAM slave inserting 2 wait states per beat -> address and HWRITE held during waits; mism_cnt=0; done once.
- Preload word 0x108 with 0xDEAD, then read 4 beats from 0x100 with seed 0xA0 -> mism_cnt=1, mism_addr=0x108.
- Write 3 beats from 0x3FC -> addresses 0x3FC(NONSEQ), 0x400(NONSEQ), 0x404(SEQ).
- Slave returns ERROR on beat 1 of 8 -> err=1, mism_addr=beat-1 address, HTRANS=IDLE on the second error cycle, no beat 2 issued, done pulses.
- cmd_len=0 -> done next cycle, no non-IDLE HTRANS. Separately, assert HRESET mid-burst -> all outputs at reset values on the next edge.
